kbd_display_ctrl: RTL and testbench

//  Sequencer between the PS/2 scancode receiver and the 6-digit hex display decoder.

---
 rtl/kbd_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_kbd_display_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_display_ctrl.sv
// Scancode sequencer between the PS/2 receiver and the hex display decoder.
// It parses the E0/F0 prefixes, tracks the held key, looks up its ASCII code in
// an external synchronous ROM and counts key presses.
module kbd_display_ctrl #(
  parameter int unsigned ROM_LAT        = 1,
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sc_data,
  input  logic       sc_valid,
  output logic       sc_ready,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] make_code,
  output logic [7:0] ascii,
  output logic [7:0] count,
  output logic       ext,
  output logic       key_held,
  output logic [5:0] blank
);

  localparam int unsigned TMR_W = 20;
  localparam int unsigned LAT_W = 2;

  localparam logic [7:0]       BYTE_E0  = 8'hE0;
  localparam logic [7:0]       BYTE_F0  = 8'hF0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PREFIX_TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_E0 = 2'd1,
    GOT_F0 = 2'd2,
    LOOKUP = 2'd3
  } state_t;

  state_t           state;
  logic             pend_ext;
  logic [TMR_W-1:0] tmr;
  logic [LAT_W-1:0] lat_cnt;

  logic xfer;
  logic is_e0;
  logic is_f0;
  logic same_key;
  logic in_prefix;
  logic tmr_expired;

  // Decode the current byte and the prefix timeout condition.
  always_comb begin
    xfer        = sc_valid & sc_ready;
    is_e0       = (sc_data == BYTE_E0);
    is_f0       = (sc_data == BYTE_F0);
    same_key    = key_held && (sc_data == make_code) && (pend_ext == ext);
    in_prefix   = (state == GOT_E0) || (state == GOT_F0);
    tmr_expired = in_prefix && !xfer && (tmr == TMR_LAST);
  end

  // Parser state, prefix timer, ROM lookup and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend_ext  <= 1'b0;
      tmr       <= '0;
      lat_cnt   <= '0;
      sc_ready  <= 1'b1;
      rom_addr  <= 8'h00;
      make_code <= 8'h00;
      ascii     <= 8'h00;
      count     <= 8'h00;
      ext       <= 1'b0;
      key_held  <= 1'b0;
      blank     <= 6'b001111;
    end else begin
      case (state)
        IDLE, GOT_E0: begin
          if (xfer) begin
            tmr <= '0;
            if (is_e0) begin
              state    <= GOT_E0;
              pend_ext <= 1'b1;
            end else if (is_f0) begin
              state <= GOT_F0;
            end else if (same_key) begin
              // Typematic repeat of the held key: nothing changes.
              state    <= IDLE;
              pend_ext <= 1'b0;
            end else begin
              make_code <= sc_data;
              ext       <= pend_ext;
              rom_addr  <= sc_data;
              count     <= count + 8'd1;
              lat_cnt   <= '0;
              sc_ready  <= 1'b0;
              pend_ext  <= 1'b0;
              state     <= LOOKUP;
            end
          end
        end

        GOT_F0: begin
          if (xfer) begin
            tmr <= '0;
            if (is_e0) begin
              pend_ext <= 1'b1;
            end else if (!is_f0) begin
              // Only the release of the held key (same E0 flavour) counts.
              if (same_key) begin
                key_held <= 1'b0;
                blank    <= 6'b001111;
              end
              pend_ext <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        LOOKUP: begin
          if (lat_cnt == LAT_LAST) begin
            ascii    <= ext ? 8'h00 : rom_data;
            key_held <= 1'b1;
            blank    <= 6'b000000;
            sc_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase

      // A prefix left dangling too long is dropped without generating an event.
      if (tmr_expired) begin
        state    <= IDLE;
        pend_ext <= 1'b0;
        tmr      <= '0;
      end else if (in_prefix && !xfer) begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_kbd_display_ctrl.sv
// Bench for kbd_display_ctrl: directed scenarios plus random scancode streams,
// checked against a transaction-level keyboard model.
module tb_kbd_display_ctrl;

  localparam int unsigned PT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sc_data;
  logic       sc_valid;
  logic       sc_ready;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] make_code;
  logic [7:0] ascii;
  logic [7:0] count;
  logic       ext;
  logic       key_held;
  logic [5:0] blank;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: visible outputs plus pending prefix flags.
  logic [7:0] m_make, m_ascii, m_count;
  logic       m_ext, m_held, m_pe, m_pf;

  kbd_display_ctrl #(.ROM_LAT(1), .PREFIX_TIMEOUT(PT)) dut (
    .clk(clk), .reset(reset), .sc_data(sc_data), .sc_valid(sc_valid),
    .sc_ready(sc_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .make_code(make_code), .ascii(ascii), .count(count), .ext(ext),
    .key_held(key_held), .blank(blank)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    case (a)
      8'h1C:   return 8'h61;
      8'h75:   return 8'h38;
      default: return a ^ 8'h3C;
    endcase
  endfunction

  // One-cycle synchronous ASCII ROM.
  logic [7:0] rom_q = 8'h00;
  always @(posedge clk) rom_q <= rom_val(rom_addr);
  assign rom_data = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_make = 8'h00; m_ascii = 8'h00; m_count = 8'h00;
    m_ext = 1'b0; m_held = 1'b0; m_pe = 1'b0; m_pf = 1'b0;
  endtask

  // Keyboard behaviour: prefixes accumulate, a plain byte completes an event.
  task automatic model_byte(input logic [7:0] b, input int idle);
    if ((m_pe || m_pf) && idle >= int'(PT)) begin
      m_pe = 1'b0; m_pf = 1'b0;
    end
    if (b == 8'hE0) m_pe = 1'b1;
    else if (b == 8'hF0) m_pf = 1'b1;
    else begin
      if (m_pf) begin
        if (m_held && b == m_make && m_pe == m_ext) m_held = 1'b0;
      end else if (!(m_held && b == m_make && m_pe == m_ext)) begin
        m_make  = b;
        m_ext   = m_pe;
        m_count = m_count + 8'd1;
        m_ascii = m_pe ? 8'h00 : rom_val(b);
        m_held  = 1'b1;
      end
      m_pe = 1'b0; m_pf = 1'b0;
    end
  endtask

  // Presents one byte after 'idle' empty cycles; returns on the negedge after transfer.
  task automatic send(input logic [7:0] b, input int idle);
    int w;
    sc_valid = 1'b0;
    repeat (idle) @(negedge clk);
    sc_data  = b;
    sc_valid = 1'b1;
    w = 0;
    while (sc_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (sc_ready !== 1'b1) chk("ready_wait", 32'(sc_ready), 32'd1);
    @(negedge clk);
    sc_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int w;
    w = 0;
    while (sc_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".sc_ready"},  32'(sc_ready),  32'd1);
    chk({tag, ".make_code"}, 32'(make_code), 32'(m_make));
    chk({tag, ".ascii"},     32'(ascii),     32'(m_ascii));
    chk({tag, ".count"},     32'(count),     32'(m_count));
    chk({tag, ".ext"},       32'(ext),       32'(m_ext));
    chk({tag, ".key_held"},  32'(key_held),  32'(m_held));
    chk({tag, ".blank"},     32'(blank),     32'({2'b00, {4{~m_held}}}));
  endtask

  task automatic send_m(input logic [7:0] b, input int idle, input string tag);
    send(b, idle);
    model_byte(b, idle);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sc_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".sc_ready"},  32'(sc_ready),  32'd1);
    chk({tag, ".rom_addr"},  32'(rom_addr),  32'h00);
    chk({tag, ".make_code"}, 32'(make_code), 32'h00);
    chk({tag, ".ascii"},     32'(ascii),     32'h00);
    chk({tag, ".count"},     32'(count),     32'h00);
    chk({tag, ".ext"},       32'(ext),       32'd0);
    chk({tag, ".key_held"},  32'(key_held),  32'd0);
    chk({tag, ".blank"},     32'(blank),     32'h0F);
  endtask

  initial begin
    reset = 1'b1; sc_valid = 1'b0; sc_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");

    // 1: press 1C, ascii arrives two cycles after accept, then release
    send(8'h1C, 0);
    model_byte(8'h1C, 0);
    chk("t1.ready_stall", 32'(sc_ready), 32'd0);
    chk("t1.make_early", 32'(make_code), 32'h1C);
    chk("t1.count_early", 32'(count), 32'h01);
    chk("t1.ascii_early", 32'(ascii), 32'h00);
    @(negedge clk);
    chk("t1.ascii_mid", 32'(ascii), 32'h00);
    @(negedge clk);
    chk("t1.ascii_exit", 32'(ascii), 32'h61);
    chk("t1.held", 32'(key_held), 32'd1);
    chk("t1.blank_on", 32'(blank), 32'h00);
    check_all("t1.make");
    send_m(8'hF0, 0, "t1.f0");
    send_m(8'h1C, 0, "t1.brk");
    chk("t1.blank_off", 32'(blank), 32'h0F);
    chk("t1.count_keep", 32'(count), 32'h01);

    // 2: auto-repeat does not count and does not stall
    do_reset();
    send_m(8'h1C, 0, "t2.first");
    for (int i = 0; i < 3; i++) begin
      send(8'h1C, 0);
      model_byte(8'h1C, 0);
      chk("t2.repeat_ready", 32'(sc_ready), 32'd1);
    end
    check_all("t2.end");
    chk("t2.count", 32'(count), 32'h01);

    // 3: count wraps FF -> 00
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send((i % 2 == 0) ? 8'h15 : 8'h29, 0);
      model_byte((i % 2 == 0) ? 8'h15 : 8'h29, 0);
    end
    check_all("t3.ff");
    chk("t3.count_ff", 32'(count), 32'hFF);
    send_m(8'h1C, 0, "t3.wrap");
    chk("t3.count_00", 32'(count), 32'h00);
    chk("t3.make", 32'(make_code), 32'h1C);
    send_m(8'hF0, 0, "t3.f0");
    send_m(8'h1C, 0, "t3.brk");

    // 4: extended key; plain release ignored, extended release honoured
    do_reset();
    send_m(8'hE0, 0, "t4.e0");
    send_m(8'h75, 1, "t4.make");
    chk("t4.ext", 32'(ext), 32'd1);
    chk("t4.ascii", 32'(ascii), 32'h00);
    chk("t4.count", 32'(count), 32'h01);
    send_m(8'hF0, 0, "t4.f0a");
    send_m(8'h75, 0, "t4.plainbrk");
    chk("t4.still_held", 32'(key_held), 32'd1);
    send_m(8'hE0, 0, "t4.e0b");
    send_m(8'hF0, 0, "t4.f0b");
    send_m(8'h75, 0, "t4.extbrk");
    chk("t4.released", 32'(key_held), 32'd0);

    // 5: prefix timeout turns a would-be break into a make; one cycle short does not
    do_reset();
    send_m(8'hF0, 0, "t5.f0");
    send_m(8'h1C, int'(PT), "t5.to_make");
    chk("t5.count", 32'(count), 32'h01);
    chk("t5.held", 32'(key_held), 32'd1);
    send_m(8'hF0, 0, "t5.f0b");
    send_m(8'h1C, int'(PT) - 1, "t5.brk");
    chk("t5.released", 32'(key_held), 32'd0);

    // 6: reset during LOOKUP discards the in-flight ROM result
    do_reset();
    send(8'h1C, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t6.rst");
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("t6.ascii_stays", 32'(ascii), 32'h00);
    check_all("t6.after");

    // Random scancode streams with varied gaps around the prefix timeout.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r, s, idle;
      logic [7:0] b;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4, 9:    b = 8'h1C;
        5:       b = 8'h75;
        6:       b = 8'h15;
        7:       b = 8'h29;
        default: b = 8'($urandom_range(0, 255));
      endcase
      s = int'($urandom_range(0, 19));
      if (s < 14)      idle = int'($urandom_range(0, 2));
      else if (s < 16) idle = int'(PT) - 1;
      else if (s < 18) idle = int'(PT);
      else             idle = int'(PT) + 3;
      send_m(b, idle, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
